// File: rtl/fetch.sv
// Program-counter fetch stage: holds the PC, advances by 4 or loads a taken beq target.
// Optional build macro FETCH_BRANCH_ALIGN_EN word-aligns branch targets before loading.
module fetch #(
  parameter int                 ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              z,
  input  logic              b,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] target;
  logic              taken;

  assign taken = b & z;

  // Low two target bits are either cleared (word-aligned fetch) or passed through.
  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_target
      if (gi < 2) begin : g_low
`ifdef FETCH_BRANCH_ALIGN_EN
        assign target[gi] = 1'b0;
`else
        assign target[gi] = b_addr[gi];
`endif
      end else begin : g_high
        assign target[gi] = b_addr[gi];
      end
    end
  endgenerate

  // Sequential step wraps modulo 2^ADDR_W with no carry out.
  always_comb begin
    pc_next = pc_reg + ADDR_W'(4);
    if (taken) begin
      pc_next = target;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_reg <= RESET_ADDR;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign addr = pc_reg;

endmodule

// File: tb/tb_fetch.sv
// Directed self-checking bench for the fetch PC stage.
// Expected values are hand-computed; alignment expectations follow FETCH_BRANCH_ALIGN_EN.
module tb_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] b_addr;
  logic        z;
  logic        b;
  logic [31:0] addr;

  int total;
  int bad;

  fetch #(.ADDR_W(32), .RESET_ADDR(32'h0)) dut (
    .clk    (clk),
    .reset  (reset),
    .b_addr (b_addr),
    .z      (z),
    .b      (b),
    .addr   (addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input logic rst, input logic bb, input logic zz,
                      input logic [31:0] ba, input logic [31:0] exp, input string tag);
    reset  = rst;
    b      = bb;
    z      = zz;
    b_addr = ba;
    @(posedge clk);
    #1;
    total++;
    assert (addr === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, addr, exp);
    end
    $display("step %s reset=%b b=%b z=%b b_addr=%h addr=%h expected=%h",
             tag, rst, bb, zz, ba, addr, exp);
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b0;
    b      = 1'b0;
    z      = 1'b0;
    b_addr = 32'h0;

    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset");
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_hold");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h4, "seq_4");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h8, "seq_8");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'hC, "seq_12");

    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_midrun");
    step(1'b1, 1'b1, 1'b1, 32'h8, 32'h8, "branch_8");
    step(1'b1, 1'b1, 1'b1, 32'h10, 32'h10, "branch_16");
    step(1'b1, 1'b1, 1'b0, 32'h40, 32'h14, "b_no_z");
    step(1'b1, 1'b0, 1'b1, 32'h40, 32'h18, "z_no_b");

    step(1'b0, 1'b1, 1'b1, 32'h80, 32'h0, "reset_over_branch");
    step(1'b1, 1'b1, 1'b1, 32'h0, 32'h0, "self_loop");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h4, "after_loop");

    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, "branch_top");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, "wrap");

`ifdef FETCH_BRANCH_ALIGN_EN
    step(1'b1, 1'b1, 1'b1, 32'hB, 32'h8, "branch_unaligned");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'hC, "seq_after_unaligned");
`else
    step(1'b1, 1'b1, 1'b1, 32'hB, 32'hB, "branch_unaligned");
    step(1'b1, 1'b0, 1'b0, 32'h0, 32'hF, "seq_after_unaligned");
`endif

    step(1'b1, 1'b1, 1'b1, 32'h1234_5670, 32'h1234_5670, "branch_far");
    step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, "reset_from_far");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch.md
# fetch

Program-counter fetch stage of the single-cycle CPU. Holds the current instruction address and presents it to instruction memory. On every clock it either advances sequentially by 4 or loads an absolute branch target when a conditional branch (beq) is taken. It sits between the control/ALU, which supply the branch flag, zero flag and target, and the instruction memory, which consumes `addr`.

## Interface
- `ADDR_W`, default 32: width of the program counter and address ports.
- `RESET_ADDR`, default 0: value loaded into the PC on reset.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `b_addr`  in  ADDR_W  absolute branch target address.
- `z`  in  1  ALU zero flag (compare-equal result).
- `b`  in  1  branch instruction indicator from control.
- `addr`  out  ADDR_W  current PC / instruction fetch address (registered).

## Operation
- Internal PC register drives `addr` directly; no combinational path from inputs to `addr`.
- At each rising `clk` edge, in priority order:
  - `reset` == 0: PC <= `RESET_ADDR`.
  - else if `b` & `z`: branch taken, PC <= `b_addr` (absolute, not PC-relative).
  - else: PC <= PC + 4.
- `b` = 1 with `z` = 0: not taken, sequential increment.
- `z` = 1 with `b` = 0: ignored, sequential increment.
- Arithmetic: PC + 4 is modulo 2^ADDR_W. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- `b_addr` is loaded unmodified when not masked (see Configuration), including a target equal to the current PC. That case is a self-loop and is legal.
- Reset overrides a simultaneous taken branch.
- Reset asserted mid-run takes effect at the next edge regardless of PC value.

## Timing
- Latency: inputs sampled at edge N determine `addr` after edge N; one-cycle latency.
- `addr` after power-up, before the first reset edge, is undefined. Benches must apply reset first.
- Reset value of `addr`: `RESET_ADDR` (0), valid from the first edge at which `reset` is low.
- While `reset` is held low, `addr` stays at `RESET_ADDR` every cycle.
- The first increment happens on the first edge with `reset` high.
- `b`, `z` and `b_addr` must be stable around the rising edge; they are sampled only at that edge.
- No handshake or stall. The PC advances every cycle.

## Configuration
- `FETCH_BRANCH_ALIGN_EN`
  - Defined: the low two bits of `b_addr` are forced to 0 before loading. A taken branch always yields a word-aligned PC, e.g. `b_addr` = 0x0000_000B loads 0x0000_0008.
  - Undefined: `b_addr` is loaded verbatim, all bits.
  - Sequential and reset behaviour are identical in both builds.

## Test plan
- Reset then free-run: hold `reset`=0 for one edge (`b`=`z`=0) -> `addr`=0. Release for 3 edges -> `addr` = 4, 8, 12.
- Taken branch: after reset, `b`=1, `z`=1, `b_addr`=8 for one edge -> `addr`=8. Next edge with `b_addr`=16, `b`=`z`=1 -> `addr`=16.
- Not-taken cases from PC=16:
  - `b`=1, `z`=0, `b_addr`=0x40 -> `addr`=20.
  - Then `b`=0, `z`=1 -> `addr`=24.
- Reset priority: `reset`=0 with `b`=`z`=1 and `b_addr`=0x80 -> `addr`=0. Release with `b`=`z`=1 and `b_addr`=0 -> `addr` stays 0 (self-loop).
- Wrap-around: branch to 0xFFFF_FFFC, then one sequential edge -> `addr`=0x0000_0000.
- Alignment option: branch with `b_addr`=0x0000_000B.
  - With `FETCH_BRANCH_ALIGN_EN` -> `addr`=0x8.
  - Without it -> `addr`=0xB, and the next sequential edge gives 0xF.
